// File: rtl/ppu_scan_doubler.sv
`default_nettype none
// ============================================================================
// Module   : ppu_scan_doubler
// Purpose  : Captures PPU scanlines into a ping-pong line buffer and re-emits
//            each line SCALE_Y times with every pixel repeated SCALE_X times
//            on a valid/ready stream; counts and flags dropped lines.
// Revision : 1.0  initial release
// ============================================================================
module ppu_scan_doubler #(
  parameter int PIX_W   = 8,
  parameter int LINE_W  = 256,
  parameter int LINES   = 240,
  parameter int SCALE_X = 2,
  parameter int SCALE_Y = 2
) (
  input  logic             clk_ppu,
  input  logic             rst_ppu_n,
  input  logic [PIX_W-1:0] pixel,
  input  logic             pixel_en,
  input  logic             vblank,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eol,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam int               c_X_W       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int               c_Y_W       = $clog2(LINES + 1);
  localparam logic [c_X_W-1:0] c_X_LAST    = c_X_W'(LINE_W - 1);
  localparam logic [c_X_W-1:0] c_X_ZERO    = '0;
  localparam logic [c_Y_W-1:0] c_Y_END     = c_Y_W'(LINES);
  localparam logic [1:0]       c_RX_LAST   = 2'(SCALE_X - 1);
  localparam logic [1:0]       c_RY_LAST   = 2'(SCALE_Y - 1);
  localparam logic             c_FIRST_EOL = (LINE_W == 1) && (SCALE_X == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Line storage: two banks of one scanline each
  logic [PIX_W-1:0] r_mem [2][LINE_W];

  // Write-side state
  logic             r_vb_q;
  logic [c_X_W-1:0] r_wr_x;
  logic [c_Y_W-1:0] r_wr_y;
  logic             r_wr_bank;
  logic             r_dropping;
  logic [1:0]       r_full;
  logic [1:0]       r_tag_zero;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  // Read-side state
  state_t           r_state;
  logic             r_rd_bank;
  logic [c_X_W-1:0] r_x;
  logic [1:0]       r_rx;
  logic [1:0]       r_ry;
  logic [PIX_W-1:0] r_out_pixel;
  logic             r_out_valid;
  logic             r_out_sof;
  logic             r_out_eol;

  // Write-side decode
  logic w_vb_rise;
  logic w_take;
  logic w_rd_free;
  logic w_bank_busy;
  logic w_line_start;
  logic w_line_end;
  logic w_drop_now;
  logic w_wr_en;

  assign w_vb_rise    = vblank & ~r_vb_q;
  // Pixels past the last visible line are ignored until the next frame
  assign w_take       = pixel_en & (r_wr_y != c_Y_END);
  assign w_rd_free    = (r_state == ST_DONE);
  // A bank the reader releases this very cycle counts as free
  assign w_bank_busy  = r_full[r_wr_bank] & ~(w_rd_free & (r_rd_bank == r_wr_bank));
  assign w_line_start = w_take & (r_wr_x == c_X_ZERO);
  assign w_line_end   = w_take & (r_wr_x == c_X_LAST);
  // Drop decision is made on the first pixel and held for the rest of the line
  assign w_drop_now   = w_line_start ? w_bank_busy : r_dropping;
  assign w_wr_en      = w_take & ~w_drop_now;

  // Next-beat counters for the emit sequence (ry outer, x middle, rx inner)
  logic [c_X_W-1:0] w_nx;
  logic [1:0]       w_nrx;
  logic [1:0]       w_nry;
  logic             w_last;

  // Advance the (ry, x, rx) beat position by one
  always_comb begin
    w_nrx  = r_rx + 2'd1;
    w_nx   = r_x;
    w_nry  = r_ry;
    w_last = (r_rx == c_RX_LAST) && (r_x == c_X_LAST) && (r_ry == c_RY_LAST);
    if (r_rx == c_RX_LAST) begin
      w_nrx = 2'd0;
      w_nx  = r_x + c_X_W'(1);
      if (r_x == c_X_LAST) begin
        w_nx  = c_X_ZERO;
        w_nry = r_ry + 2'd1;
      end
    end
  end

  // Line buffer write port; dropped lines never touch memory
  always_ff @(posedge clk_ppu) begin
    if (w_wr_en) begin
      r_mem[r_wr_bank][r_wr_x] <= pixel;
    end
  end

  // Write-side bookkeeping: position, bank flags, drop accounting
  always_ff @(posedge clk_ppu or negedge rst_ppu_n) begin
    if (!rst_ppu_n) begin
      r_vb_q     <= 1'b0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_wr_bank  <= 1'b0;
      r_dropping <= 1'b0;
      r_full     <= 2'b00;
      r_tag_zero <= 2'b00;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_vb_q <= vblank;

      if (w_line_start) begin
        r_dropping <= w_bank_busy;
        if (w_bank_busy) begin
          r_overflow <= 1'b1;
          if (r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
          end
        end
      end

      // Reader release first; a writer completion on the same bank wins
      if (w_rd_free) begin
        r_full[r_rd_bank] <= 1'b0;
      end
      // A dropped line leaves wr_bank alone so the next line retries the
      // oldest bank, which is also the next one the reader frees
      if (w_line_end && !w_drop_now) begin
        r_full[r_wr_bank]     <= 1'b1;
        r_tag_zero[r_wr_bank] <= (r_wr_y == '0);
        r_wr_bank             <= ~r_wr_bank;
      end

      // vblank after the pixel so a coincident final pixel completes its line
      if (w_vb_rise) begin
        r_wr_x <= '0;
        r_wr_y <= '0;
      end else if (w_take) begin
        if (r_wr_x == c_X_LAST) begin
          r_wr_x <= '0;
          r_wr_y <= r_wr_y + c_Y_W'(1);
        end else begin
          r_wr_x <= r_wr_x + c_X_W'(1);
        end
      end
    end
  end

  // Read FSM: wait for a full bank, prime the buffer read, stream beats, release
  always_ff @(posedge clk_ppu or negedge rst_ppu_n) begin
    if (!rst_ppu_n) begin
      r_state     <= ST_IDLE;
      r_rd_bank   <= 1'b0;
      r_x         <= '0;
      r_rx        <= 2'd0;
      r_ry        <= 2'd0;
      r_out_pixel <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_x  <= '0;
          r_rx <= 2'd0;
          r_ry <= 2'd0;
          if (r_full[r_rd_bank]) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_state     <= ST_EMIT;
          r_out_valid <= 1'b1;
          r_out_pixel <= r_mem[r_rd_bank][c_X_ZERO];
          r_out_sof   <= r_tag_zero[r_rd_bank];
          r_out_eol   <= c_FIRST_EOL;
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (w_last) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b0;
              r_out_sof   <= 1'b0;
              r_out_eol   <= 1'b0;
            end else begin
              r_x         <= w_nx;
              r_rx        <= w_nrx;
              r_ry        <= w_nry;
              r_out_pixel <= r_mem[r_rd_bank][w_nx];
              r_out_sof   <= 1'b0;
              r_out_eol   <= (w_nx == c_X_LAST) && (w_nrx == c_RX_LAST);
            end
          end
        end
        default: begin
          r_rd_bank <= ~r_rd_bank;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_pixel = r_out_pixel;
  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_eol   = r_out_eol;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ppu_scan_doubler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_scan_doubler
// Purpose  : Directed self-checking bench for ppu_scan_doubler.
// Revision : 1.0  initial release
// ============================================================================
module tb_ppu_scan_doubler;

  localparam int PIX_W   = 8;
  localparam int LINE_W  = 256;
  localparam int LINES   = 240;
  localparam int SCALE_X = 2;
  localparam int SCALE_Y = 2;
  localparam int BPR     = LINE_W * SCALE_X;
  localparam int BPL     = BPR * SCALE_Y;

  logic             clk_ppu   = 1'b0;
  logic             rst_ppu_n = 1'b0;
  logic [PIX_W-1:0] pixel     = '0;
  logic             pixel_en  = 1'b0;
  logic             vblank    = 1'b0;
  logic             out_ready = 1'b0;
  logic [PIX_W-1:0] out_pixel;
  logic             out_valid;
  logic             out_sof;
  logic             out_eol;
  logic             overflow;
  logic [7:0]       drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ppu_scan_doubler #(
    .PIX_W  (PIX_W),
    .LINE_W (LINE_W),
    .LINES  (LINES),
    .SCALE_X(SCALE_X),
    .SCALE_Y(SCALE_Y)
  ) u_dut (
    .clk_ppu  (clk_ppu),
    .rst_ppu_n(rst_ppu_n),
    .pixel    (pixel),
    .pixel_en (pixel_en),
    .vblank   (vblank),
    .out_pixel(out_pixel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof  (out_sof),
    .out_eol  (out_eol),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk_ppu = ~clk_ppu;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output scoreboard: each queued entry is seed | (sof_expected << 16);
  // line pixels are (seed + x) mod 256.
  int         m_q[$];
  int         m_cur      = 0;
  int         m_beat     = 0;
  int         m_beats    = 0;
  int         m_lines    = 0;
  int         m_data_err = 0;
  int         m_eol_err  = 0;
  int         m_sof_err  = 0;
  int         m_hold_err = 0;
  int         m_gap_err  = 0;
  int         m_unexp    = 0;
  int         m_sof_cnt  = 0;
  int         m_eol_cnt  = 0;
  logic       m_stall    = 1'b0;
  logic [7:0] m_hold_pix = '0;
  logic       m_hold_sof = 1'b0;
  logic       m_hold_eol = 1'b0;

  // Inputs change at posedge+1, so the negedge sees the values the next edge uses
  always @(negedge clk_ppu) begin
    int         px;
    logic [7:0] exp_pix;
    if (!rst_ppu_n) begin
      m_beat  = 0;
      m_stall = 1'b0;
      m_q.delete();
    end else begin
      if (m_stall && (!out_valid || out_pixel != m_hold_pix ||
                      out_sof != m_hold_sof || out_eol != m_hold_eol))
        m_hold_err++;
      if (out_valid && out_ready) begin
        if (m_beat == 0) begin
          if (m_q.size() != 0) m_cur = m_q.pop_front();
          else begin
            m_cur = 0;
            m_unexp++;
          end
        end
        px      = (m_beat % BPR) / SCALE_X;
        exp_pix = 8'((m_cur & 'hFFFF) + px);
        if (out_pixel != exp_pix) m_data_err++;
        if (out_eol != ((m_beat % BPR) == BPR - 1)) m_eol_err++;
        if (out_sof != ((m_beat == 0) && m_cur[16])) m_sof_err++;
        if (out_eol) m_eol_cnt++;
        if (out_sof) m_sof_cnt++;
        m_beats++;
        m_beat++;
        if (m_beat == BPL) begin
          m_beat = 0;
          m_lines++;
        end
      end else if (!out_valid && m_beat != 0) begin
        m_gap_err++;
      end
      m_stall    = out_valid && !out_ready;
      m_hold_pix = out_pixel;
      m_hold_sof = out_sof;
      m_hold_eol = out_eol;
    end
  end

  task automatic tick();
    @(posedge clk_ppu);
    #1;
  endtask

  task automatic send_line(input int seed, input int n, input bit vb_last);
    for (int x = 0; x < n; x++) begin
      pixel    = 8'(seed + x);
      pixel_en = 1'b1;
      vblank   = vb_last && (x == n - 1);
      tick();
    end
    pixel_en = 1'b0;
    vblank   = 1'b0;
  endtask

  task automatic wait_lines(input string tag, input int target);
    for (int i = 0; i < 4000 && m_lines < target; i++) tick();
    chk(tag, m_lines, target);
  endtask

  task automatic push(input int seed, input int sof);
    m_q.push_back(seed | (sof << 16));
  endtask

  initial begin
    int base;
    int cnt;
    int found;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_pixel", out_pixel, 0);
    chk("rst_sof", out_sof, 0);
    chk("rst_eol", out_eol, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst_ppu_n = 1'b1;
    tick();

    // ---- line 0, full throughput, latency ----
    out_ready = 1'b1;
    push(0, 1);
    send_line(0, LINE_W, 1'b0);
    chk("lat_edge0_valid", out_valid, 0);
    tick();
    chk("lat_edge1_valid", out_valid, 0);
    tick();
    chk("lat_edge2_valid", out_valid, 1);
    chk("lat_first_pix", out_pixel, 0);
    chk("lat_first_sof", out_sof, 1);
    wait_lines("l0_lines", 1);
    chk("l0_beats", m_beats, 1024);
    chk("l0_sof_cnt", m_sof_cnt, 1);
    chk("l0_eol_cnt", m_eol_cnt, 2);
    chk("l0_data_err", m_data_err, 0);
    chk("l0_eol_err", m_eol_err, 0);
    chk("l0_sof_err", m_sof_err, 0);

    // ---- backpressure at x=37 for 10 cycles ----
    push(100, 0);
    send_line(100, LINE_W, 1'b0);
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      if (out_valid && out_pixel == 8'd137) found = 1;
      else tick();
    end
    chk("stall_found", found, 1);
    out_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_pixel != 8'd137 || !out_valid) cnt++;
    end
    chk("stall_hold_pix", cnt, 0);
    out_ready = 1'b1;
    wait_lines("stall_lines", 2);
    chk("stall_beats", m_beats, 2048);
    chk("stall_data_err", m_data_err, 0);
    chk("stall_hold_err", m_hold_err, 0);
    chk("stall_gap_err", m_gap_err, 0);

    // ---- vblank mid-line discards the partial line ----
    send_line(50, 100, 1'b0);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("vb_no_output", cnt, 0);
    chk("vb_overflow", overflow, 0);
    chk("vb_drop_cnt", drop_cnt, 0);
    base = m_sof_cnt;
    push(60, 1);
    send_line(60, LINE_W, 1'b0);
    wait_lines("vb_next_lines", 3);
    chk("vb_next_sof", m_sof_cnt, base + 1);
    // vblank rising on the last pixel: that line still completes
    push(65, 0);
    send_line(65, LINE_W, 1'b1);
    wait_lines("vb_tie_lines", 4);
    push(66, 1);
    send_line(66, LINE_W, 1'b0);
    wait_lines("vb_tie_next_lines", 5);
    chk("vb_tie_sof", m_sof_cnt, base + 2);
    chk("vb_data_err", m_data_err, 0);
    chk("vb_sof_err", m_sof_err, 0);
    chk("vb_unexp", m_unexp, 0);

    // ---- three lines under backpressure: the third is dropped ----
    out_ready = 1'b0;
    send_line(10, LINE_W, 1'b0);
    send_line(20, LINE_W, 1'b0);
    chk("drop_pre_overflow", overflow, 0);
    send_line(30, LINE_W, 1'b0);
    chk("drop_overflow", overflow, 1);
    chk("drop_cnt_1", drop_cnt, 1);
    push(10, 0);
    push(20, 0);
    out_ready = 1'b1;
    wait_lines("drop_first_out", 6);
    push(40, 0);
    send_line(40, LINE_W, 1'b0);
    wait_lines("drop_all_out", 8);
    chk("drop_cnt_after", drop_cnt, 1);
    chk("drop_data_err", m_data_err, 0);
    chk("drop_unexp", m_unexp, 0);
    chk("drop_gap_err", m_gap_err, 0);

    // ---- asynchronous reset during EMIT ----
    push(70, 0);
    send_line(70, LINE_W, 1'b0);
    for (int i = 0; i < 100 && !out_valid; i++) tick();
    for (int i = 0; i < 20; i++) tick();
    chk("emit_before_rst", out_valid, 1);
    rst_ppu_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_pixel", out_pixel, 0);
    chk("arst_sof", out_sof, 0);
    chk("arst_eol", out_eol, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    tick();
    tick();
    rst_ppu_n = 1'b1;
    base = m_lines;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("arst_no_output", cnt, 0);
    push(80, 1);
    send_line(80, LINE_W, 1'b0);
    wait_lines("arst_fresh_line", base + 1);
    chk("arst_data_err", m_data_err, 0);
    chk("arst_sof_err", m_sof_err, 0);

    // ---- drop counter saturation ----
    // wr_y=1 now; 239 lines fill the frame: two accepted, 237 dropped
    out_ready = 1'b0;
    for (int l = 1; l < LINES; l++) send_line(l, LINE_W, 1'b0);
    chk("sat_cnt_237", drop_cnt, 237);
    send_line(7, 16, 1'b0);
    chk("frame_bound_ignored", drop_cnt, 237);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
    for (int l = 0; l < 25; l++) send_line(l, LINE_W, 1'b0);
    chk("sat_cnt_255", drop_cnt, 255);
    chk("sat_overflow", overflow, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ppu_scan_doubler.md
Name: ppu_scan_doubler

Overview:
- Sits directly downstream of the nes core's pixel/pixel_en/vblank outputs, in the clk_ppu domain.
- Captures each 256-pixel PPU scanline into a ping-pong line buffer.
- Re-emits each line SCALE_Y times with each pixel repeated SCALE_X times, on a valid/ready stream toward the video output path.
- Decouples the PPU's bursty pixel timing from the display-side consumer and flags dropped lines.

Parameters:
- PIX_W, 8, width of pixel (palette index) bus
- LINE_W, 256, captured pixels per scanline
- LINES, 240, visible lines captured per frame
- SCALE_X, 2, horizontal repeat count per pixel (1..4)
- SCALE_Y, 2, vertical repeat count per line (1..4)

Ports:
- clk_ppu  in  1  PPU clock; the only clock
- rst_ppu_n  in  1  asynchronous active-low reset
- pixel  in  PIX_W  PPU pixel value, sampled when pixel_en=1
- pixel_en  in  1  one PPU pixel valid this cycle
- vblank  in  1  PPU vblank level; rising edge marks end of frame
- out_pixel  out  PIX_W  output pixel
- out_valid  out  1  out_pixel valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_sof  out  1  qualifies first output pixel of a frame
- out_eol  out  1  qualifies last output pixel of each output line
- overflow  out  1  sticky: a line was dropped; cleared only by reset
- drop_cnt  out  8  dropped-line count, saturates at 255

Behaviour:
- Reset (async, rst_ppu_n=0): out_valid=0, out_pixel=0, out_sof=0, out_eol=0, overflow=0, drop_cnt=0. Both banks empty, wr_x=0, wr_y=0, wr_bank=0, rd_bank=0, read FSM IDLE. Reset mid-line or mid-output abandons all data; no partial output after release.
- Write side:
  - Each pixel_en cycle writes pixel to bank[wr_bank][wr_x] and increments wr_x.
  - At wr_x=LINE_W-1: mark bank full, tag it with line number wr_y, toggle wr_bank, wr_x←0, wr_y←wr_y+1.
- Drop rule:
  - If the target bank is still full when the first pixel of a line arrives (wr_x=0), the whole line is discarded. LINE_W pixels are still counted and wr_y still advances.
  - On that first pixel: overflow←1 and drop_cnt increments, saturating at 255.
- Frame bound: once wr_y=LINES, pixel_en is ignored until the vblank rising edge.
- vblank rising edge (vblank=1, previous sample 0): wr_x←0, wr_y←0. A partial line in progress is discarded silently, with no overflow and no bank marked full. Banks already full are kept and drained normally.
- Read FSM:
  - IDLE: when bank[rd_bank] is full, go to LOAD.
  - LOAD: one cycle for the synchronous buffer read.
  - EMIT: present pixels.
  - DONE: after the last pixel of the last repeat, clear bank[rd_bank] full, toggle rd_bank, return to IDLE.
- Output order: for ry in 0..SCALE_Y-1, for x in 0..LINE_W-1, for rx in 0..SCALE_X-1, emit bank[x]. Total LINE_W*SCALE_X*SCALE_Y beats per line.
- Handshake:
  - out_valid=1 with out_ready=0 holds out_pixel, out_sof and out_eol stable.
  - A beat transfers only when out_valid & out_ready. With out_ready held at 1, sustained throughput is one beat per cycle.
  - out_valid never drops mid-line.
- out_sof=1 on beat (ry=0, x=0, rx=0) of the line tagged 0. out_eol=1 on beat (x=LINE_W-1, rx=SCALE_X-1) of every repeat.
- Latency: first out_valid asserts 2 cycles after the clk_ppu edge on which a bank is marked full (IDLE→LOAD→EMIT).
- Same-bank events: if the reader frees a bank on the same cycle the writer checks it for the drop rule, the bank counts as free and the line is accepted.
- Tie: a vblank rising edge on the same cycle as the final pixel of a line: the line completes first, then wr_x and wr_y reset.

Test Plan:
- Reset, then feed line 0 as pixels 0..255 with pixel_en every cycle and out_ready=1 → 1024 beats: 0,0,1,1,…,255,255 twice. out_sof on beat 0 only; out_eol on beats 511 and 1023; first out_valid 2 cycles after the line completes.
- Hold out_ready=0 for 10 cycles mid-line at x=37 → out_pixel stays 37 throughout; no beat lost or duplicated; total beat count is still 1024.
- Hold out_ready=0 while writing 3 full lines → line 2 is dropped: overflow=1, drop_cnt=1. After out_ready=1, lines 0 and 1 are emitted intact, and line 3 is accepted into the freed bank.
- Raise vblank after 100 pixels of a line → no output for the partial line; overflow stays 0; the next line is tagged 0 and carries out_sof.
- Deassert rst_ppu_n during EMIT → all outputs 0 immediately (asynchronous). After release, output starts only after a fresh complete line.
- Force 300 dropped lines → drop_cnt saturates at 255 and overflow stays 1.
